// File: rtl/vga_timing_rx_pkg.sv
// vga_timing_rx_pkg
//   Shared constants and types for the 640x480@60 VGA timing receiver:
//   nominal line/frame geometry, counter and bus widths, and the lock
//   state machine encoding.
package vga_timing_rx_pkg;

   // Nominal 640x480@60 geometry (pixels / lines)
   localparam int DEF_H_SYNC  = 96;
   localparam int DEF_H_BP    = 48;
   localparam int DEF_H_ACT   = 640;
   localparam int DEF_H_TOTAL = 800;
   localparam int DEF_V_SYNC  = 2;
   localparam int DEF_V_BP    = 33;
   localparam int DEF_V_ACT   = 480;
   localparam int DEF_V_TOTAL = 525;

   // Counter and bus widths
   localparam int HCNT_W = 11;
   localparam int VCNT_W = 10;
   localparam int POS_W  = 10;
   localparam int RGB_W  = 12;
   localparam int ERR_W  = 8;

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2
   } rx_state_t;

endpackage

// File: rtl/vga_timing_rx_if.sv
// vga_timing_rx_if
//   Bundles the incoming VGA stream and the recovered timing outputs.
//   master : stream source / consumer of recovered timing (testbench, link)
//   slave  : the receiver (vga_timing_rx)
//   Signals:
//     hs, vs       active-low syncs          rgb     {R,G,B} 4 bits each
//     x, y         active-area coordinates   de      pixel valid (locked)
//     pix          rgb aligned with x/y/de   frame_start  frame pulse
//     locked       geometry verified         err     violation pulse
//     err_cnt      saturating violation count
interface vga_timing_rx_if;
   import vga_timing_rx_pkg::*;

   logic             hs;
   logic             vs;
   logic [RGB_W-1:0] rgb;
   logic [POS_W-1:0] x;
   logic [POS_W-1:0] y;
   logic             de;
   logic [RGB_W-1:0] pix;
   logic             frame_start;
   logic             locked;
   logic             err;
   logic [ERR_W-1:0] err_cnt;

   modport master (
      output hs, vs, rgb,
      input  x, y, de, pix, frame_start, locked, err, err_cnt
   );

   modport slave (
      input  hs, vs, rgb,
      output x, y, de, pix, frame_start, locked, err, err_cnt
   );

endinterface

// File: rtl/vga_timing_rx_axis_cnt.sv
// vga_axis_cnt
//   Saturating up-counter with synchronous load-to-zero, used for both the
//   horizontal (pixel) and vertical (line) position counters.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset (count -> 0)
//     en_i       advance the count by one (sticks at all-ones)
//     load_i     force the count to zero; wins over en_i
//     cnt_o      current count
module vga_axis_cnt #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic         load_i,
   output logic [W-1:0] cnt_o
);

   localparam logic [W-1:0] CNT_MAX = '1;

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_timing_rx.sv
// vga_timing_rx
//   Receiving end of the VGA link. Registers the active-low syncs and RGB,
//   recovers pixel/line position from the sync edges, checks line and frame
//   geometry against the nominal timing, and reports lock and error status.
//   Ports:
//     clk    pixel clock, rising edge
//     rst    asynchronous active-high reset
//     bus    vga_timing_rx_if.slave: hs/vs/rgb in; x, y, de, pix,
//            frame_start, locked, err, err_cnt out (all registered)
//   Latency: input sample -> x/y/de/pix/frame_start/err is 2 clk.
module vga_timing_rx
   import vga_timing_rx_pkg::*;
#(
   parameter int H_SYNC  = DEF_H_SYNC,
   parameter int H_BP    = DEF_H_BP,
   parameter int H_ACT   = DEF_H_ACT,
   parameter int H_TOTAL = DEF_H_TOTAL,
   parameter int V_SYNC  = DEF_V_SYNC,
   parameter int V_BP    = DEF_V_BP,
   parameter int V_ACT   = DEF_V_ACT,
   parameter int V_TOTAL = DEF_V_TOTAL
) (
   input  logic            clk,
   input  logic            rst,
   vga_timing_rx_if.slave  bus
);

   localparam logic [HCNT_W-1:0] H_SYNC_LAST  = HCNT_W'(H_SYNC - 1);
   localparam logic [HCNT_W-1:0] H_LINE_LAST  = HCNT_W'(H_TOTAL - 1);
   localparam logic [HCNT_W-1:0] H_ACT_LO     = HCNT_W'(H_SYNC + H_BP);
   localparam logic [HCNT_W-1:0] H_ACT_HI     = HCNT_W'(H_SYNC + H_BP + H_ACT - 1);
   localparam logic [HCNT_W-1:0] H_CNT_MAX    = '1;
   localparam logic [VCNT_W-1:0] V_FRAME_LAST = VCNT_W'(V_TOTAL - 1);
   localparam logic [VCNT_W-1:0] V_ACT_LO     = VCNT_W'(V_SYNC + V_BP);
   localparam logic [VCNT_W-1:0] V_ACT_HI     = VCNT_W'(V_SYNC + V_BP + V_ACT - 1);
   localparam logic [VCNT_W-1:0] V_CNT_MAX    = '1;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (v == '1) ? v : v + ERR_W'(1);
   endfunction

   logic              hs_q;
   logic              vs_hf_q;     // vs as seen at the previous hs fall
   logic [RGB_W-1:0]  rgb_q;
   logic              hs_fall;
   logic              hs_rise;
   logic              frame_evt;
   logic              viol;
   logic [HCNT_W-1:0] hcnt;
   logic [VCNT_W-1:0] vcnt;
   logic              in_act;

   rx_state_t         state_q;
   rx_state_t         state_d;
   logic              err_set;
   logic              fs_set;
   logic              err_evt_q;
   logic              fs_evt_q;

   logic [POS_W-1:0]  x_q;
   logic [POS_W-1:0]  y_q;
   logic              de_q;
   logic [RGB_W-1:0]  pix_q;
   logic              frame_start_q;
   logic              locked_q;
   logic              err_q;
   logic [ERR_W-1:0]  err_cnt_q;

   // ---- Stage 1: input register ----
   // Syncs idle high out of reset so the first sample cannot look like an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hs_q    <= 1'b1;
         vs_hf_q <= 1'b1;
         rgb_q   <= '0;
      end else begin
         hs_q  <= bus.hs;
         rgb_q <= bus.rgb;
         if (hs_fall) begin
            vs_hf_q <= bus.vs;
         end
      end
   end

   assign hs_fall   = hs_q & ~bus.hs;
   assign hs_rise   = ~hs_q & bus.hs;
   // A frame starts on the first hs fall that sees vs low after one that saw it high.
   assign frame_evt = hs_fall & ~bus.vs & vs_hf_q;

   // Counters are checked at their pre-update value: hcnt holds the count
   // of the last sample of the line/pulse that is ending.
   assign viol = (hs_fall   && (hcnt != H_LINE_LAST))  ||
                 (hs_rise   && (hcnt != H_SYNC_LAST))  ||
                 (frame_evt && (vcnt != V_FRAME_LAST)) ||
                 (hcnt == H_CNT_MAX) || (vcnt == V_CNT_MAX);

   vga_axis_cnt #(.W(HCNT_W)) u_hcnt (
      .clk    (clk),
      .rst    (rst),
      .en_i   (1'b1),
      .load_i (hs_fall),
      .cnt_o  (hcnt)
   );

   vga_axis_cnt #(.W(VCNT_W)) u_vcnt (
      .clk    (clk),
      .rst    (rst),
      .en_i   (hs_fall),
      .load_i (frame_evt),
      .cnt_o  (vcnt)
   );

   // ---- Lock state machine (updates alongside the counters) ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_SEARCH;
      end else begin
         state_q <= state_d;
      end
   end

   // A violation outranks a coincident frame start.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SEARCH:  if (frame_evt) state_d = ST_ACQUIRE;
         ST_ACQUIRE: if (viol) state_d = ST_SEARCH;
                     else if (frame_evt) state_d = ST_LOCKED;
         ST_LOCKED:  if (viol) state_d = ST_SEARCH;
         default:    state_d = ST_SEARCH;
      endcase
   end

   // err is qualified by the state the violation was seen in; frame_start by
   // the state being entered, so it lines up with the registered locked flag.
   always_comb begin
      err_set = viol && (state_q != ST_SEARCH);
      fs_set  = frame_evt && (state_d == ST_LOCKED);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_evt_q <= 1'b0;
         fs_evt_q  <= 1'b0;
      end else begin
         err_evt_q <= err_set;
         fs_evt_q  <= fs_set;
      end
   end

   assign in_act = (hcnt >= H_ACT_LO) && (hcnt <= H_ACT_HI) &&
                   (vcnt >= V_ACT_LO) && (vcnt <= V_ACT_HI);

   // ---- Stage 2: output register ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q           <= '0;
         y_q           <= '0;
         de_q          <= 1'b0;
         pix_q         <= '0;
         frame_start_q <= 1'b0;
         locked_q      <= 1'b0;
         err_q         <= 1'b0;
         err_cnt_q     <= '0;
      end else begin
         locked_q      <= (state_q == ST_LOCKED);
         de_q          <= in_act && (state_q == ST_LOCKED);
         pix_q         <= (in_act && (state_q == ST_LOCKED)) ? rgb_q : '0;
         frame_start_q <= fs_evt_q;
         err_q         <= err_evt_q;
         if (in_act) begin
            x_q <= POS_W'(hcnt - H_ACT_LO);
            y_q <= POS_W'(vcnt - V_ACT_LO);
         end
         if (err_evt_q) begin
            err_cnt_q <= sat_inc(err_cnt_q);
         end
      end
   end

   assign bus.x           = x_q;
   assign bus.y           = y_q;
   assign bus.de          = de_q;
   assign bus.pix         = pix_q;
   assign bus.frame_start = frame_start_q;
   assign bus.locked      = locked_q;
   assign bus.err         = err_q;
   assign bus.err_cnt     = err_cnt_q;

endmodule
